serial_frame_rx: RTL

- Responder end of the slow bit-serial link whose initiator generates a divided-down sck from clk12MHz and steps through an 8-phase sequence.
- Oversamples external sck_in/sdi_in on clk12MHz, shifts in 8-bit MSB-first frames on sck rising edges, and presents each completed byte with a one-cycle strobe.
- Aborts stalled frames via timeout.
- Sits beside led_driver in a top; data and bit_cnt are intended for LED display.

---
 rtl/serial_pkg.sv | 12 +
 rtl/sync_rise.sv | 27 ++
 rtl/serial_frame_rx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial frame link.
// TIMEOUT_DEFAULT is also used by the initiator's sck divider.
package serial_pkg;
    localparam int FRAME_BITS = 8;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam logic [25:0] TIMEOUT_DEFAULT = 26'd40_000_000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for one asynchronous input plus a registered
// rising-edge detector on the synchronized copy.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk12MHz,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk12MHz or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/serial_frame_rx.sv
// Responder for the slow bit-serial link: oversamples sck/sdi, shifts in
// MSB-first bytes on sck rises and aborts stalled frames after TIMEOUT cycles.
//   state   | meaning
//   S_IDLE  | no frame in progress, timeout counter held at 0
//   S_SHIFT | 1..7 bits received, timeout counter running
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   TIMEOUT_W   = 26,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT     = TIMEOUT_W'(TIMEOUT_DEFAULT)
) (
    input  logic                 clk12MHz,
    input  logic                 rst,
    input  logic                 sck_in,
    input  logic                 sdi_in,
    output logic [FRAME_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic [BIT_CNT_W-1:0] bit_cnt,
    output logic                 frame_err
);
    logic                  w_sck_s_unused;
    logic                  w_sck_rise;
    logic                  w_sdi_s;
    logic                  w_sdi_rise_unused;

    state_t                r_state,   w_next_state;
    logic [FRAME_BITS-1:0] r_shreg,   w_next_shreg;
    logic [BIT_CNT_W-1:0]  r_bit_cnt, w_next_bit_cnt;
    logic [TIMEOUT_W-1:0]  r_tcnt,    w_next_tcnt;
    logic [FRAME_BITS-1:0] r_data,    w_next_data;
    logic                  r_valid,   w_next_valid;
    logic                  r_ferr,    w_next_ferr;
    logic [FRAME_BITS-1:0] w_shifted;

    sync_rise #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .i_async  (sck_in),
        .o_sync   (w_sck_s_unused),
        .o_rise   (w_sck_rise)
    );

    // Same depth as sck so the sampled bit lines up with the detected rise.
    sync_rise #(.STAGES(SYNC_STAGES)) u_sdi_sync (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .i_async  (sdi_in),
        .o_sync   (w_sdi_s),
        .o_rise   (w_sdi_rise_unused)
    );

    assign w_shifted = {r_shreg[FRAME_BITS-2:0], w_sdi_s};

    always_comb begin
        w_next_state   = r_state;
        w_next_shreg   = r_shreg;
        w_next_bit_cnt = r_bit_cnt;
        w_next_tcnt    = r_tcnt;
        w_next_data    = r_data;
        w_next_valid   = 1'b0;
        w_next_ferr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_tcnt = '0;
                if (w_sck_rise) begin
                    w_next_shreg   = w_shifted;
                    w_next_bit_cnt = BIT_CNT_W'(1);
                    w_next_state   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A rise in the same cycle as the terminal count keeps the frame alive.
                if (w_sck_rise) begin
                    w_next_tcnt = '0;
                    if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        w_next_data    = w_shifted;
                        w_next_valid   = 1'b1;
                        w_next_shreg   = '0;
                        w_next_bit_cnt = '0;
                        w_next_state   = S_IDLE;
                    end else begin
                        w_next_shreg   = w_shifted;
                        w_next_bit_cnt = r_bit_cnt + BIT_CNT_W'(1);
                    end
                end else if (r_tcnt == TIMEOUT - TIMEOUT_W'(1)) begin
                    w_next_ferr    = 1'b1;
                    w_next_shreg   = '0;
                    w_next_bit_cnt = '0;
                    w_next_tcnt    = '0;
                    w_next_state   = S_IDLE;
                end else begin
                    w_next_tcnt = r_tcnt + TIMEOUT_W'(1);
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk12MHz or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tcnt    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shreg   <= w_next_shreg;
            r_bit_cnt <= w_next_bit_cnt;
            r_tcnt    <= w_next_tcnt;
            r_data    <= w_next_data;
            r_valid   <= w_next_valid;
            r_ferr    <= w_next_ferr;
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state == S_SHIFT);
    assign bit_cnt   = r_bit_cnt;
    assign frame_err = r_ferr;
endmodule
